piso_bit_serializer: RTL and testbench

//  Upstream feeder for the serial pattern-detector FSMs (e.g. the 1010 detector).

---
 rtl/serial_pkg.sv | 13 +
 rtl/piso_bit_serializer.sv | 125 ++++++++++++
 tb/tb_piso_bit_serializer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial feeder and the pattern-detector FSMs it drives.
package serial_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out feeder: takes a word on valid/ready and emits it one bit per clock,
// with an optional idle gap between words.
module piso_bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             frame_done,
  output state_t           dbg_state_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             bit_out_q, bit_valid_q, frame_done_q;
  logic             ready_state;
  logic             accept;
  logic             last_bit;

  function automatic logic lead_bit(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? s[WIDTH-1] : s[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return (MSB_FIRST != 0) ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  // Handshake: a word transfers on any posedge where data_valid && data_ready; data_ready
  // depends only on state (never on data_valid) and data_in is ignored on every other edge.
  assign last_bit    = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
  assign ready_state = (state_q == ST_IDLE) || ((GAP_CYCLES == 0) && last_bit);
  assign data_ready  = ready_state && !reset;
  assign accept      = data_valid && ready_state;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          sreg_d  = data_in;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          if (GAP_CYCLES == 0) begin
            // Back-to-back reload keeps the bit stream contiguous.
            if (accept) begin
              sreg_d = data_in;
              cnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end else begin
          sreg_d = shift_once(sreg_q);
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sreg_d  = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      bit_out_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      bit_valid_q  <= (state_d == ST_SHIFT);
      bit_out_q    <= (state_d == ST_SHIFT) && lead_bit(sreg_d);
      frame_done_q <= (state_d == ST_SHIFT) && (cnt_d == CNT_LAST);
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q == ST_SHIFT) || (state_q == ST_GAP);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Directed bench for piso_bit_serializer: three instances cover default, gapped and LSB-first builds.
module tb_piso_bit_serializer;
  import serial_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       rdy [3];
  logic       bo  [3];
  logic       bv  [3];
  logic       bsy [3];
  logic       fd  [3];
  state_t     dbg [3];

  int         n_cmp;
  int         n_err;
  logic [0:0] exp_q [$];
  int         det_pos [$];
  logic [3:0] hist;
  int         pos;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset(reset), .data_in(din[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
    .bit_out(bo[0]), .bit_valid(bv[0]), .busy(bsy[0]), .frame_done(fd[0]), .dbg_state_o(dbg[0])
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2)) dut_g (
    .clk(clk), .reset(reset), .data_in(din[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
    .bit_out(bo[1]), .bit_valid(bv[1]), .busy(bsy[1]), .frame_done(fd[1]), .dbg_state_o(dbg[1])
  );

  piso_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_l (
    .clk(clk), .reset(reset), .data_in(din[2]), .data_valid(dv[2]), .data_ready(rdy[2]),
    .bit_out(bo[2]), .bit_valid(bv[2]), .busy(bsy[2]), .frame_done(fd[2]), .dbg_state_o(dbg[2])
  );

  // ---------------- checker / scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue n expected stream bits, leftmost (bit n-1) transmitted first.
  task automatic push_bits(input logic [15:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(s[i]);
  endtask

  // ---------------- drivers ----------------
  task automatic start_word(input int k, input logic [7:0] w);
    @(negedge clk);
    for (int t = 0; t < 50 && !rdy[k]; t++) @(negedge clk);
    check("start_rdy", rdy[k], 1);
    din[k] = w;
    dv[k]  = 1'b1;
  endtask

  task automatic collect(input int k, input int n, input bit rdy_last, input bit do_reload,
                         input logic [7:0] reload_w, input bit scramble, input string tag);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_bv"}, bv[k], 1);
      if (exp_q.size() == 0) begin
        check({tag, "_exp_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_bo"}, bo[k], e);
      end
      hist = {hist[2:0], bo[k]};
      pos++;
      if (hist == 4'b1010) det_pos.push_back(pos);
      check({tag, "_fd"}, fd[k], (i % 8 == 7));
      check({tag, "_rdy"}, rdy[k], rdy_last && (i % 8 == 7));
      check({tag, "_busy"}, bsy[k], 1);
      if (i == 0 && !do_reload) dv[k] = 1'b0;
      if (do_reload && i == 7) din[k] = reload_w;
      if (i == n - 1) dv[k] = 1'b0;
      if (scramble) din[k] = ~din[k];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    hist  = '0;
    pos   = 0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      dv[k]  = 1'b0;
    end

    #1;
    check("rst_rdy", rdy[0], 0);
    check("rst_bv", bv[0], 0);
    check("rst_bo", bo[0], 0);
    check("rst_busy", bsy[0], 0);
    check("rst_fd", fd[0], 0);
    check("rst_state", dbg[0], ST_IDLE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_rdy", rdy[0], 1);

    // T1: 8'hA5 MSB first
    push_bits(16'b10100101, 8);
    start_word(0, 8'hA5);
    collect(0, 8, 1'b1, 1'b0, 8'h00, 1'b0, "t1");
    @(negedge clk);
    check("t1_idle", dbg[0], ST_IDLE);
    check("t1_idle_bv", bv[0], 0);
    check("t1_idle_busy", bsy[0], 0);

    // T2: back-to-back 8'hA0, 8'h0A; 1010 detector model on the stream
    hist = '0;
    pos  = 0;
    det_pos.delete();
    push_bits(16'b1010000000001010, 16);
    start_word(0, 8'hA0);
    collect(0, 16, 1'b1, 1'b1, 8'h0A, 1'b0, "t2");
    check("t2_det_count", det_pos.size(), 2);
    if (det_pos.size() == 2) begin
      check("t2_det_pos0", det_pos[0], 4);
      check("t2_det_pos1", det_pos[1], 16);
    end
    @(negedge clk);
    check("t2_idle", dbg[0], ST_IDLE);

    // T3: gapped build, two words 8'hC3 then 8'h5A
    push_bits(16'b11000011, 8);
    start_word(1, 8'hC3);
    collect(1, 8, 1'b0, 1'b0, 8'h00, 1'b0, "t3a");
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check("t3_gap_bv", bv[1], 0);
      check("t3_gap_bo", bo[1], 0);
      check("t3_gap_rdy", rdy[1], 0);
      check("t3_gap_state", dbg[1], ST_GAP);
    end
    @(negedge clk);
    check("t3_idle_rdy", rdy[1], 1);
    check("t3_idle_state", dbg[1], ST_IDLE);
    check("t3_idle_bv", bv[1], 0);
    din[1] = 8'h5A;
    dv[1]  = 1'b1;
    push_bits(16'b01011010, 8);
    collect(1, 8, 1'b0, 1'b0, 8'h00, 1'b0, "t3b");

    // T4: LSB-first build, 8'h01
    push_bits(16'b10000000, 8);
    start_word(2, 8'h01);
    collect(2, 8, 1'b1, 1'b0, 8'h00, 1'b0, "t4");

    // T5: reset during bit 3 of 8'hFF
    start_word(0, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) dv[0] = 1'b0;
      check("t5_pre_bv", bv[0], 1);
      check("t5_pre_bo", bo[0], 1);
      check("t5_pre_fd", fd[0], 0);
    end
    reset = 1'b1;
    #1;
    check("t5_async_bv", bv[0], 0);
    check("t5_async_bo", bo[0], 0);
    check("t5_async_fd", fd[0], 0);
    check("t5_async_rdy", rdy[0], 0);
    check("t5_async_busy", bsy[0], 0);
    @(negedge clk);
    check("t5_hold_fd", fd[0], 0);
    reset = 1'b0;
    #1;
    check("t5_rel_rdy", rdy[0], 1);
    check("t5_rel_state", dbg[0], ST_IDLE);
    check("t5_rel_bv", bv[0], 0);
    push_bits(16'b10010110, 8);
    start_word(0, 8'h96);
    collect(0, 8, 1'b1, 1'b0, 8'h00, 1'b0, "t5");

    // T6: valid low for 5 cycles, then 8'h3C with data_in toggling mid-shift
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_wait_rdy", rdy[0], 1);
      check("t6_wait_bv", bv[0], 0);
      check("t6_wait_state", dbg[0], ST_IDLE);
      din[0] = 8'($urandom_range(0, 255));
      dv[0]  = 1'b0;
    end
    push_bits(16'b00111100, 8);
    start_word(0, 8'h3C);
    collect(0, 8, 1'b1, 1'b0, 8'h00, 1'b1, "t6");
    @(negedge clk);
    check("t6_idle", dbg[0], ST_IDLE);
    check("t6_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
